// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_mux2.sv
// Single-bit 2:1 multiplexer: y follows a when sel=0, b when sel=1.
module mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin packet arbiter sharing one valid/ready channel between two sources.
// Optional stall timeout with forced release is enabled by defining MUX2_ARB_TIMEOUT_EN.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy,
  output logic              timeout_err
);

  state_t state, state_nxt;
  logic   rr_ptr, rr_nxt;
  logic   gnt_valid, gnt_last, other_valid;
  logic   expire;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
    end
  end

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             stall, accept;

  // Stall and accept are derived from state directly to keep the counter off the comb path.
  assign stall  = ((state == GNT0) && !in0_valid) || ((state == GNT1) && !in1_valid);
  assign accept = ((state == GNT0) && in0_valid && out_ready) ||
                  ((state == GNT1) && in1_valid && out_ready);
  assign expire = stall && (stall_cnt == STALL_MAX);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt <= '0;
    end else if (accept || (state_nxt != state)) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  assign timeout_err = expire;

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    sel         = SEL_IN0;
    busy        = 1'b0;
    in0_ready   = 1'b0;
    in1_ready   = 1'b0;
    gnt_valid   = 1'b0;
    gnt_last    = 1'b0;
    other_valid = 1'b0;

    case (state)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          state_nxt = (rr_ptr == SEL_IN1) ? GNT1 : GNT0;
        end else if (in0_valid) begin
          state_nxt = GNT0;
        end else if (in1_valid) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        sel         = SEL_IN0;
        busy        = 1'b1;
        gnt_valid   = in0_valid;
        gnt_last    = in0_last;
        other_valid = in1_valid;
        in0_ready   = out_ready;
      end
      GNT1: begin
        sel         = SEL_IN1;
        busy        = 1'b1;
        gnt_valid   = in1_valid;
        gnt_last    = in1_last;
        other_valid = in0_valid;
        in1_ready   = out_ready;
      end
      default: state_nxt = IDLE;
    endcase

    // Packet end hands over without a bubble; with no other requester the grant is released.
    if (busy && gnt_valid && out_ready && gnt_last) begin
      rr_nxt = ~sel;
      if (other_valid) begin
        state_nxt = (sel == SEL_IN0) ? GNT1 : GNT0;
      end else begin
        state_nxt = IDLE;
      end
    end else if (busy && expire) begin
      rr_nxt    = ~sel;
      state_nxt = IDLE;
    end
  end

  assign out_valid = gnt_valid;

  for (genvar i = 0; i < DATA_W; i++) begin : g_data_mux
    mux2 u_mux_data (
      .a  (in0_data[i]),
      .b  (in1_data[i]),
      .sel(sel),
      .y  (out_data[i])
    );
  end

  mux2 u_mux_last (
    .a  (in0_last),
    .b  (in1_last),
    .sel(sel),
    .y  (out_last)
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: vector table, directed corner cases, random vs model.
// Timeout expectations follow MUX2_ARB_TIMEOUT_EN.
module tb_mux2_rr_arbiter;

  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 4;
`ifdef MUX2_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              in0_valid, in0_last, in0_ready;
  logic [DATA_W-1:0] in0_data;
  logic              in1_valid, in1_last, in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              out_valid, out_last, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              sel, busy, timeout_err;

  int checks = 0;
  int passed = 0;

  mux2_rr_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst_n;
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       ordy;
    logic       e_sel;
    logic       e_busy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ol;
    logic       e_r0;
    logic       e_r1;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic rst_n, logic v0, logic [7:0] d0, logic l0,
                              logic v1, logic [7:0] d1, logic l1, logic ordy,
                              logic e_sel, logic e_busy, logic e_ov, logic [7:0] e_od,
                              logic e_ol, logic e_r0, logic e_r1);
    vec_t v;
    v.rst_n = rst_n; v.v0 = v0; v.d0 = d0; v.l0 = l0;
    v.v1 = v1; v.d1 = d1; v.l1 = l1; v.ordy = ordy;
    v.e_sel = e_sel; v.e_busy = e_busy; v.e_ov = e_ov; v.e_od = e_od;
    v.e_ol = e_ol; v.e_r0 = e_r0; v.e_r1 = e_r1;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    Reset_n   = v.rst_n;
    in0_valid = v.v0; in0_data = v.d0; in0_last = v.l0;
    in1_valid = v.v1; in1_data = v.d1; in1_last = v.l1;
    out_ready = v.ordy;
  endtask

  // Data and last are only meaningful while out_valid is expected high.
  task automatic checkOutput(input string name, input logic e_sel, input logic e_busy,
                             input logic e_ov, input logic [7:0] e_od, input logic e_ol,
                             input logic e_r0, input logic e_r1, input logic e_te);
    logic bad;
    checks++;
    bad = ({sel, busy, out_valid, in0_ready, in1_ready, timeout_err} !==
           {e_sel, e_busy, e_ov, e_r0, e_r1, e_te});
    if (e_ov && ({out_data, out_last} !== {e_od, e_ol})) bad = 1'b1;
    if (bad) begin
      $display("[TB] FAIL %s: got sel=%b busy=%b ov=%b od=%h ol=%b r0=%b r1=%b te=%b, want sel=%b busy=%b ov=%b od=%h ol=%b r0=%b r1=%b te=%b",
               name, sel, busy, out_valid, out_data, out_last, in0_ready, in1_ready, timeout_err,
               e_sel, e_busy, e_ov, e_od, e_ol, e_r0, e_r1, e_te);
    end else begin
      passed++;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  task automatic clearInputs();
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    clearInputs();
    tick();
    Reset_n = 1'b1;
  endtask

  // Reference model state: current owner (-1 none), next round-robin turn, stall count.
  int         owner, turn, stall;
  logic       sv[2];
  logic [7:0] sd[2];
  logic       sl[2];
  int         rem[2];

  initial begin
    vecs[0]  = mk(0, 1,8'hA0,0, 1,8'hB0,0, 1,  0,0,0,8'h00,0,0,0);
    vecs[1]  = mk(1, 1,8'hA1,0, 0,8'h00,0, 1,  0,0,0,8'h00,0,0,0);
    vecs[2]  = mk(1, 1,8'hA1,0, 0,8'h00,0, 1,  0,1,1,8'hA1,0,1,0);
    vecs[3]  = mk(1, 1,8'hA2,0, 0,8'h00,0, 1,  0,1,1,8'hA2,0,1,0);
    vecs[4]  = mk(1, 1,8'hA3,1, 0,8'h00,0, 1,  0,1,1,8'hA3,1,1,0);
    vecs[5]  = mk(1, 0,8'h00,0, 0,8'h00,0, 1,  0,0,0,8'h00,0,0,0);
    vecs[6]  = mk(0, 1,8'hB1,0, 1,8'hC1,0, 1,  0,0,0,8'h00,0,0,0);
    vecs[7]  = mk(1, 1,8'hB1,0, 1,8'hC1,0, 1,  0,0,0,8'h00,0,0,0);
    vecs[8]  = mk(1, 1,8'hB1,0, 1,8'hC1,0, 1,  0,1,1,8'hB1,0,1,0);
    vecs[9]  = mk(1, 1,8'hB2,1, 1,8'hC1,0, 1,  0,1,1,8'hB2,1,1,0);
    vecs[10] = mk(1, 0,8'h00,0, 1,8'hC1,0, 1,  1,1,1,8'hC1,0,0,1);
    vecs[11] = mk(1, 0,8'h00,0, 1,8'hC2,1, 1,  1,1,1,8'hC2,1,0,1);
    vecs[12] = mk(1, 1,8'hD1,1, 1,8'hE1,1, 1,  0,0,0,8'h00,0,0,0);
    vecs[13] = mk(1, 1,8'hD1,1, 1,8'hE1,1, 1,  0,1,1,8'hD1,1,1,0);
    vecs[14] = mk(1, 0,8'h00,0, 1,8'hE1,1, 1,  1,1,1,8'hE1,1,0,1);
    vecs[15] = mk(1, 0,8'h00,0, 0,8'h00,0, 1,  0,0,0,8'h00,0,0,0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      sample();
      checkOutput($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_busy, vecs[i].e_ov,
                  vecs[i].e_od, vecs[i].e_ol, vecs[i].e_r0, vecs[i].e_r1, 1'b0);
      tick();
    end

    // Backpressure mid-packet with the other source waiting.
    doReset();
    in0_valid = 1'b1; in0_data = 8'hF1; in0_last = 1'b0;
    in1_valid = 1'b1; in1_data = 8'hC9; in1_last = 1'b1;
    sample(); checkOutput("bp_idle", 0,0,0,8'h00,0,0,0,0); tick();
    sample(); checkOutput("bp_first", 0,1,1,8'hF1,0,1,0,0); tick();
    in0_data = 8'hF2; in0_last = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample(); checkOutput("bp_hold", 0,1,1,8'hF2,1,0,0,0); tick();
    end
    out_ready = 1'b1;
    sample(); checkOutput("bp_release", 0,1,1,8'hF2,1,1,0,0); tick();
    in0_valid = 1'b0;
    sample(); checkOutput("bp_handover", 1,1,1,8'hC9,1,0,1,0); tick();
    in1_valid = 1'b0;
    sample(); checkOutput("bp_done", 0,0,0,8'h00,0,0,0,0);

    // Asynchronous reset between beats of a packet.
    doReset();
    in0_valid = 1'b1; in0_data = 8'h61; in0_last = 1'b0;
    sample(); tick();
    sample(); checkOutput("rst_beat1", 0,1,1,8'h61,0,1,0,0); tick();
    in0_data = 8'h62; in0_last = 1'b1;
    #2 Reset_n = 1'b0;
    #1 checkOutput("rst_async", 0,0,0,8'h00,0,0,0,0);
    for (int k = 0; k < 3; k++) begin
      sample(); checkOutput("rst_hold", 0,0,0,8'h00,0,0,0,0); tick();
    end
    in0_valid = 1'b0;
    Reset_n = 1'b1;
    sample(); checkOutput("rst_after", 0,0,0,8'h00,0,0,0,0); tick();

    // Stall on the granted source: forced release only when the timeout is built in.
    doReset();
    in1_valid = 1'b1; in1_data = 8'h71; in1_last = 1'b0;
    sample(); tick();
    sample(); checkOutput("to_grant", 1,1,1,8'h71,0,0,1,0); tick();
    in1_valid = 1'b0;
    for (int k = 0; k < TIMEOUT_CYC; k++) begin
      sample(); checkOutput($sformatf("to_stall%0d", k), 1,1,0,8'h00,0,0,1, TO_EN && (k == TIMEOUT_CYC-1));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      sample(); checkOutput("to_after", !TO_EN, !TO_EN, 0,8'h00,0,0, !TO_EN, 0); tick();
    end

    // Randomized traffic against the packet-level model.
    doReset();
    owner = -1; turn = 0; stall = 0;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; sd[i] = '0; sl[i] = 1'b0; rem[i] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int   o;
      logic rdy[2];
      logic e_te;
      in0_valid = sv[0]; in0_data = sd[0]; in0_last = sl[0];
      in1_valid = sv[1]; in1_data = sd[1]; in1_last = sl[1];
      sample();
      o = (owner < 0) ? 0 : owner;
      e_te = TO_EN && (owner >= 0) && !sv[o] && (stall == TIMEOUT_CYC - 1);
      rdy[0] = (owner == 0) && out_ready;
      rdy[1] = (owner == 1) && out_ready;
      checkOutput("rand", owner == 1, owner >= 0, (owner >= 0) && sv[o], sd[o], sl[o],
                  rdy[0], rdy[1], e_te);

      if (owner < 0) begin
        if (sv[0] && sv[1]) owner = turn;
        else if (sv[0])     owner = 0;
        else if (sv[1])     owner = 1;
        stall = 0;
      end else if (sv[o] && out_ready) begin
        stall = 0;
        if (sl[o]) begin
          turn  = 1 - o;
          owner = sv[1-o] ? (1 - o) : -1;
        end
      end else if (!sv[o] && TO_EN) begin
        if (stall == TIMEOUT_CYC - 1) begin
          turn = 1 - o; owner = -1; stall = 0;
        end else begin
          stall++;
        end
      end

      tick();
      for (int i = 0; i < 2; i++) begin
        if (sv[i] && rdy[i]) begin
          rem[i]--;
          sv[i] = 1'b0;
        end
        if (!sv[i] && ($urandom_range(0, 9) < 6)) begin
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          sd[i] = 8'($urandom);
          sl[i] = (rem[i] == 1);
          sv[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
